// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed 7-segment BCD display: field widths and
// active-high segment codes in {g,f,e,d,c,b,a} order.
package bcd_disp_pkg;

   localparam int BCD_W = 4;
   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; codes 10-15 render as a dash.
module bcd_to_seg7
   import bcd_disp_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered BCD input,
// leading-zero blanking, frame pulse and invalid-digit flag.
module bcd_seg_scan
   import bcd_disp_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 1000,
   parameter bit COMMON_ANODE = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [BCD_W*N_DIGITS-1:0] bcd_in,
   input  logic [N_DIGITS-1:0]       dp_in,
   input  logic                      load,
   input  logic                      blank_lz,
   output logic [SEG_W-1:0]          seg,
   output logic                      dp,
   output logic [N_DIGITS-1:0]       an,
   output logic                      frame_done,
   output logic                      err
);

   localparam int                   CNT_W    = $clog2(SCAN_DIV);
   localparam int                   IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_DIGITS - 1);
   // XOR masks that turn active-high drive into the panel's polarity; also the idle level.
   localparam logic [SEG_W-1:0]     SEG_POL  = {SEG_W{COMMON_ANODE}};
   localparam logic [N_DIGITS-1:0]  AN_POL   = {N_DIGITS{COMMON_ANODE}};

   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [BCD_W*N_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
   logic [N_DIGITS-1:0]       pend_dp_q, pend_dp_d;
   logic                      pend_valid_q, pend_valid_d;
   logic [BCD_W*N_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
   logic [N_DIGITS-1:0]       disp_dp_q, disp_dp_d;
   logic [SEG_W-1:0]          seg_q, seg_d;
   logic                      dp_q, dp_d;
   logic [N_DIGITS-1:0]       an_q, an_d;
   logic                      err_q, err_d;

   logic                      tick;
   logic                      frame_end;
   logic [BCD_W-1:0]          digit_sel;
   logic                      dp_sel;
   logic [N_DIGITS-1:0]       an_act;
   logic [N_DIGITS-1:0]       blank_vec;
   logic                      lz_run;
   logic [SEG_W-1:0]          dec_seg;

   assign tick      = (cnt_q == CNT_LAST);
   assign frame_end = tick && (idx_q == IDX_LAST);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      pend_bcd_d   = pend_bcd_q;
      pend_dp_d    = pend_dp_q;
      pend_valid_d = pend_valid_q;
      disp_bcd_d   = disp_bcd_q;
      disp_dp_d    = disp_dp_q;

      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      if (frame_end && pend_valid_q) begin
         disp_bcd_d   = pend_bcd_q;
         disp_dp_d    = pend_dp_q;
         pend_valid_d = 1'b0;
      end

      // A load coinciding with the transfer lands in pending after the old value moved out.
      if (load) begin
         pend_bcd_d   = bcd_in;
         pend_dp_d    = dp_in;
         pend_valid_d = 1'b1;
      end
   end

   // Output stage looks at next-state index/data so the pins track the slot one cycle after tick.
   always_comb begin
      digit_sel = '0;
      dp_sel    = 1'b0;
      an_act    = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            digit_sel = disp_bcd_d[BCD_W*i +: BCD_W];
            dp_sel    = disp_dp_d[i];
            an_act[i] = 1'b1;
         end
      end
   end

   // NOTE: lz_run is a scratch variable updated with blocking assignments inside the loop;
   // it must be blocking so each iteration sees the previous one's result.
   always_comb begin
      lz_run    = blank_lz;
      blank_vec = '0;
      err_d     = 1'b0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         if (disp_bcd_d[BCD_W*i +: BCD_W] > 4'd9) begin
            err_d = 1'b1;
         end
         if ((i > 0) && lz_run && (disp_bcd_d[BCD_W*i +: BCD_W] == '0)) begin
            blank_vec[i] = 1'b1;
         end else begin
            lz_run = 1'b0;
         end
      end
   end

   bcd_to_seg7 u_dec (
      .bcd_i (digit_sel),
      .seg_o (dec_seg)
   );

   always_comb begin
      seg_d = (|(blank_vec & an_act) ? SEG_BLANK : dec_seg) ^ SEG_POL;
      dp_d  = dp_sel ^ COMMON_ANODE;
      an_d  = an_act ^ AN_POL;
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_bcd_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
         disp_bcd_q   <= '0;
         disp_dp_q    <= '0;
         seg_q        <= SEG_POL;
         dp_q         <= COMMON_ANODE;
         an_q         <= AN_POL;
         err_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_bcd_q   <= pend_bcd_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
         disp_bcd_q   <= disp_bcd_d;
         disp_dp_q    <= disp_dp_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         err_q        <= err_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign err        = err_q;
   assign frame_done = frame_end;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan (4 digits, 4 clocks per slot), common-cathode and common-anode
// instances side by side, checked against a frame/slot arithmetic model.
module tb_bcd_seg_scan;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        blank_lz;

   logic [6:0]  seg0, seg1;
   logic        dp0, dp1, fd0, fd1, err0, err1;
   logic [3:0]  an0, an1;
   logic [13:0] obs0, obs1;

   assign obs0 = {seg0, dp0, an0, fd0, err0};
   assign obs1 = {seg1, dp1, an1, fd1, err1};

   bcd_seg_scan #(.N_DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0), .err(err0)
   );

   bcd_seg_scan #(.N_DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(1'b1)) dut_ca (
      .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1), .err(err1)
   );

   always #5 clk = ~clk;

   // Reference model: edges since reset release fix slot and digit; buffers follow load/frame rules.
   int          edges;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_disp_dp, m_pend_dp;
   bit          m_pv, m_blank;
   int          passed = 0;
   int          total  = 0;
   logic [6:0]  seg_lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic model_reset();
      edges     = 0;
      m_disp    = '0;
      m_pend    = '0;
      m_disp_dp = '0;
      m_pend_dp = '0;
      m_pv      = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      m_blank = blank_lz;
      if ((edges % 16 == 15) && m_pv) begin
         m_disp    = m_pend;
         m_disp_dp = m_pend_dp;
         m_pv      = 1'b0;
      end
      if (load) begin
         m_pend    = bcd_in;
         m_pend_dp = dp_in;
         m_pv      = 1'b1;
      end
      edges++;
      @(negedge clk);
   endtask

   function automatic logic [13:0] exp_out(input bit ca);
      int         idx;
      logic [3:0] d;
      logic [6:0] s;
      logic [3:0] a;
      bit         bad;
      idx = (edges / 4) % 4;
      d   = m_disp[4*idx +: 4];
      if (m_blank && idx != 0 && (m_disp >> (4*idx)) == 16'd0) s = 7'h00;
      else if (d > 4'd9) s = 7'h40;
      else s = seg_lut[d];
      a   = 4'b0001 << idx;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) if (m_disp[4*i +: 4] > 4'd9) bad = 1'b1;
      if (ca) return {~s, ~m_disp_dp[idx], ~a, edges % 16 == 15, bad};
      return {s, m_disp_dp[idx], a, edges % 16 == 15, bad};
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(9));
      return v;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; bcd_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({obs0, obs1} !== {14'h0, 7'h7F, 1'b1, 4'hF, 2'b00})
         $display("FAIL reset_state got=%h exp=%h", {obs0, obs1}, {14'h0, 7'h7F, 1'b1, 4'hF, 2'b00});
      else passed++;
      reset_n = 1'b1;
      model_reset();
      cycle();
      total++;
      if ({seg0, an0, seg1, an1} !== {7'h3F, 4'b0001, 7'h40, 4'b1110})
         $display("FAIL first_edge got=%h exp=%h", {seg0, an0, seg1, an1}, {7'h3F, 4'b0001, 7'h40, 4'b1110});
      else passed++;
      total++;
      if ({obs0, obs1} !== {exp_out(1'b0), exp_out(1'b1)})
         $display("FAIL reset_model got=%h exp=%h", {obs0, obs1}, {exp_out(1'b0), exp_out(1'b1)});
      else passed++;
   endtask

   // Load, run to the frame boundary, then check each slot against a fixed table.
   task automatic test_directed_frame(input string name, input logic [15:0] val, input logic [3:0] dpv,
                                      input bit blank, input logic [27:0] segs);
      blank_lz = blank;
      if (edges % 16 == 15) cycle();
      bcd_in = val; dp_in = dpv; load = 1'b1;
      cycle();
      load = 1'b0;
      while (edges % 16 != 0) begin
         cycle();
         total++;
         if ({obs0, obs1} !== {exp_out(1'b0), exp_out(1'b1)})
            $display("FAIL %s_model edge=%0d got=%h exp=%h", name, edges, {obs0, obs1}, {exp_out(1'b0), exp_out(1'b1)});
         else passed++;
      end
      for (int j = 0; j < 16; j++) begin
         if (j > 0) cycle();
         total++;
         if ({obs0, obs1} !== {exp_out(1'b0), exp_out(1'b1)})
            $display("FAIL %s_model edge=%0d got=%h exp=%h", name, edges, {obs0, obs1}, {exp_out(1'b0), exp_out(1'b1)});
         else passed++;
         if (j % 4 == 0) begin
            total++;
            if ({seg0, dp0, an0, seg1, dp1, an1} !==
                {segs[7*(j/4) +: 7], dpv[j/4], 4'(4'b0001 << (j/4)),
                 ~segs[7*(j/4) +: 7], ~dpv[j/4], ~4'(4'b0001 << (j/4))})
               $display("FAIL %s_slot%0d got=%h/%b/%b exp=%h/%b/%b", name, j/4, seg0, dp0, an0,
                        segs[7*(j/4) +: 7], dpv[j/4], 4'(4'b0001 << (j/4)));
            else passed++;
         end
      end
   endtask

   task automatic test_scan();
      test_directed_frame("scan_1234", 16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66});
   endtask

   task automatic test_blank_lz();
      test_directed_frame("blank_0070", 16'h0070, 4'b1000, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F});
   endtask

   task automatic test_err();
      test_directed_frame("err_00A5", 16'h00A5, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h40, 7'h6D});
      total++;
      if ({err0, err1} !== 2'b11) $display("FAIL err_set got=%b exp=11", {err0, err1});
      else passed++;
      test_directed_frame("err_0005", 16'h0005, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h6D});
      total++;
      if ({err0, err1} !== 2'b00) $display("FAIL err_clear got=%b exp=00", {err0, err1});
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] x, y, v;
      x = rand_bcd();
      y = rand_bcd();
      blank_lz = 1'b0; dp_in = '0;
      while (edges % 16 != 5) cycle();
      bcd_in = x; load = 1'b1;
      cycle();
      load = 1'b0;
      while (edges % 16 != 15) begin
         cycle();
         total++;
         if ({obs0, obs1} !== {exp_out(1'b0), exp_out(1'b1)})
            $display("FAIL b2b_model edge=%0d got=%h exp=%h", edges, {obs0, obs1}, {exp_out(1'b0), exp_out(1'b1)});
         else passed++;
      end
      total++;
      if ({fd0, fd1} !== 2'b11) $display("FAIL b2b_frame_done got=%b exp=11", {fd0, fd1});
      else passed++;
      bcd_in = y; load = 1'b1;
      cycle();
      load = 1'b0;
      for (int j = 0; j < 32; j++) begin
         if (j > 0) cycle();
         total++;
         if ({obs0, obs1} !== {exp_out(1'b0), exp_out(1'b1)})
            $display("FAIL b2b_model edge=%0d got=%h exp=%h", edges, {obs0, obs1}, {exp_out(1'b0), exp_out(1'b1)});
         else passed++;
         if (j % 4 == 0) begin
            v = (j < 16) ? x : y;
            total++;
            if (seg0 !== seg_lut[v[4*((j/4)%4) +: 4]])
               $display("FAIL b2b_frame%0d_slot%0d got=%h exp=%h", j/16, (j/4)%4, seg0, seg_lut[v[4*((j/4)%4) +: 4]]);
            else passed++;
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         load   = ($urandom_range(5) == 0);
         bcd_in = 16'($urandom);
         dp_in  = 4'($urandom);
         if ($urandom_range(49) == 0) blank_lz = ~blank_lz;
         cycle();
         total++;
         if ({obs0, obs1} !== {exp_out(1'b0), exp_out(1'b1)})
            $display("FAIL random_model edge=%0d got=%h exp=%h", edges, {obs0, obs1}, {exp_out(1'b0), exp_out(1'b1)});
         else passed++;
      end
      load = 1'b0;
   endtask

   task automatic test_reset_mid();
      blank_lz = 1'b0;
      while (edges % 16 != 2) cycle();
      bcd_in = 16'h9876; dp_in = 4'hF; load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (3) cycle();
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({obs0, obs1} !== {14'h0, 7'h7F, 1'b1, 4'hF, 2'b00})
         $display("FAIL reset_mid_inactive got=%h exp=%h", {obs0, obs1}, {14'h0, 7'h7F, 1'b1, 4'hF, 2'b00});
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int j = 0; j < 36; j++) begin
         cycle();
         total++;
         if ({obs0, obs1} !== {exp_out(1'b0), exp_out(1'b1)})
            $display("FAIL reset_mid_model edge=%0d got=%h exp=%h", edges, {obs0, obs1}, {exp_out(1'b0), exp_out(1'b1)});
         else passed++;
         if (j == 0) begin
            total++;
            if ({seg0, an0} !== {7'h3F, 4'b0001})
               $display("FAIL reset_mid_first got=%h/%b exp=3f/0001", seg0, an0);
            else passed++;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_scan();
      test_blank_lz();
      test_err();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 The module SHALL have parameter N_DIGITS, default 4, giving the number of BCD digits displayed.
REQ-002 The module SHALL have parameter SCAN_DIV, default 1000, giving the clk cycles per digit slot (minimum 2).
REQ-003 The module SHALL have parameter COMMON_ANODE, default 0; when 1, seg, dp and an are inverted.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit, an asynchronous, active-low reset.
REQ-006 The module SHALL have port bcd_in, input, 4*N_DIGITS bits, the digits; bits [3:0] are digit 0 (least significant).
REQ-007 The module SHALL have port dp_in, input, N_DIGITS bits, the per-digit decimal point requests.
REQ-008 The module SHALL have port load, input, 1 bit, a strobe that captures bcd_in and dp_in.
REQ-009 The module SHALL have port blank_lz, input, 1 bit, which enables leading-zero blanking.
REQ-010 The module SHALL have port seg, output, 7 bits, the segments {g,f,e,d,c,b,a}, with seg[0] = a.
REQ-011 The module SHALL have port dp, output, 1 bit, the decimal-point segment.
REQ-012 The module SHALL have port an, output, N_DIGITS bits, the one-hot digit enable; an[0] = digit 0.
REQ-013 The module SHALL have port frame_done, output, 1 bit, a one-cycle pulse at the end of each full scan.
REQ-014 The module SHALL have port err, output, 1 bit, high while any displayed digit is greater than 9.

Function
REQ-015 Prescaler: counts 0..SCAN_DIV-1 and wraps; tick is asserted when the count equals SCAN_DIV-1.
REQ-016 Digit index: advances on tick and wraps from N_DIGITS-1 to 0.
REQ-017 frame_done: asserted for the single cycle in which tick occurs with index = N_DIGITS-1.
REQ-018 Double buffering, load: load=1 at an edge writes bcd_in/dp_in into a pending register and sets pend_valid.
- A later load before the frame boundary overwrites the pending register (last value wins).
REQ-019 Double buffering, transfer: on the frame_done cycle with pend_valid=1, pending is copied to the display register and pend_valid is cleared.
- Only the display register drives the outputs, so no mid-frame tearing occurs.
REQ-020 Load and frame_done in the same cycle: the display takes the old pending value; the new value becomes pending with pend_valid=1.
REQ-021 Decode, active-high: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); 10-15 display a dash, 40.
REQ-022 Leading-zero blanking: with blank_lz=1, zero digits from N_DIGITS-1 downward up to the first nonzero digit show seg=00.
- Digit 0 is never blanked.
- dp still follows dp_in for blanked digits.
- A digit valued 10-15 stops blanking.
REQ-023 seg, dp, an and err SHALL be registered and reflect the new index one cycle after tick.
REQ-024 Exactly one an bit is active at any time outside reset.

Reset
REQ-025 reset_n=0 SHALL asynchronously set:
- prescaler and index to 0;
- display and pending registers to 0;
- pend_valid, frame_done and err to 0;
- seg, dp and an to inactive (all 0 active-high; all 1 when COMMON_ANODE=1).
REQ-026 At the first edge after release, an SHALL select digit 0 showing "0" (seg=3F).
REQ-027 Asserting reset mid-scan SHALL discard any pending load.

Structure
REQ-028 Package bcd_disp_pkg SHALL hold the 7-bit segment codes for 0-9 and SEG_DASH=7'h40.
REQ-029 The combinational digit decoder SHALL be a sub-module, bcd_to_seg7 (4-bit in, 7-bit out, dash for values above 9).

Verification (N_DIGITS=4, SCAN_DIV=4)
REQ-030 Load 16'h1234 after reset. After the next frame_done, an SHALL step 0001/0010/0100/1000 every 4 clk with seg=66/4F/5B/06.
REQ-031 blank_lz=1 and load 16'h0070. The displayed frame SHALL show digit3=00, digit2=00, digit1=07, digit0=3F.
REQ-032 Load 16'h00A5. digit1 SHALL show 40 and err=1 after the transfer; a subsequent load of 16'h0005 SHALL clear err after its transfer.
REQ-033 Load X mid-frame, then load Y in the frame_done cycle. The next frame SHALL show X and the following frame Y.
REQ-034 Pulse reset_n low mid-scan with a load pending. Outputs SHALL go inactive immediately; after release the display SHALL show 0000 starting at digit 0 and never X.
REQ-035 With COMMON_ANODE=1, rerun REQ-030. seg, dp and an SHALL be the bitwise inverse.
